bus_router: RTL and testbench

- Parametrised single-master to NSLV-slave memory router with address decode and translation.
- Sits between the arbiter's unified memory port and the peripheral set (bram, clint, print, rom, and future slaves).
- Unlike a purely combinational decoder, it registers the request, holds it stable toward exactly one slave, and routes back only that slave's response.
- Returns an error response for unmapped addresses and for slaves that never respond (timeout).

---
 rtl/bus_router.sv | 132 +++++++++++++
 tb/tb_bus_router.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_router.sv
// Single-master to NSLV-slave memory router: registers each request, decodes it to one
// slave window, translates the address and returns only that slave's response.
module bus_router #(
  parameter int                  NSLV      = 4,
  parameter logic [NSLV*32-1:0]  BASE_ADDR = {32'h8000_0000, 32'h1000_0000, 32'h0200_0000, 32'h0000_0000},
  parameter logic [NSLV*32-1:0]  TOP_ADDR  = {32'h8010_0000, 32'h1000_1000, 32'h0200_C000, 32'h0010_0000},
  parameter int                  TIMEOUT   = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 memory_valid,
  input  logic                 memory_instr,
  input  logic [31:0]          memory_addr,
  input  logic [31:0]          memory_wdata,
  input  logic [3:0]           memory_wstrb,
  output logic [31:0]          memory_rdata,
  output logic                 memory_ready,
  output logic                 memory_error,
  output logic [NSLV-1:0]      slv_valid,
  output logic                 slv_instr,
  output logic [31:0]          slv_addr,
  output logic [31:0]          slv_wdata,
  output logic [3:0]           slv_wstrb,
  input  logic [NSLV*32-1:0]   slv_rdata,
  input  logic [NSLV-1:0]      slv_ready
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t         state;
  logic [SW-1:0]  sel;
  logic           instr_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [3:0]     wstrb_q;
  logic [CW-1:0]  count;

  logic           hit;
  logic [SW-1:0]  hit_idx;
  logic [31:0]    hit_base;
  logic           sel_ready;
  logic [31:0]    sel_rdata;
  logic           timeout_hit;

  // Scanning from the highest index down lets the lowest overlapping window win.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (memory_addr >= BASE_ADDR[i*32 +: 32] && memory_addr < TOP_ADDR[i*32 +: 32]) begin
        hit      = 1'b1;
        hit_idx  = SW'(i);
        hit_base = BASE_ADDR[i*32 +: 32];
      end
    end
  end

  assign sel_ready   = slv_ready[sel];
  assign sel_rdata   = slv_rdata[sel*32 +: 32];
  assign timeout_hit = (TIMEOUT != 0) && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= '0;
      instr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memory_valid) begin
            if (hit) begin
              sel     <= hit_idx;
              instr_q <= memory_instr;
              addr_q  <= memory_addr - hit_base;
              wdata_q <= memory_wdata;
              wstrb_q <= memory_wstrb;
              count   <= '0;
              state   <= BUSY;
            end else begin
              state   <= ERR;
            end
          end
        end
        BUSY: begin
          count <= count + CW'(1);
          if (sel_ready || timeout_hit) state <= IDLE;
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A slave's ready completes the transfer in the same cycle, and wins over a coincident timeout.
  always_comb begin
    memory_ready = 1'b0;
    memory_error = 1'b0;
    memory_rdata = '0;
    slv_valid    = '0;
    case (state)
      BUSY: begin
        slv_valid = NSLV'(1) << sel;
        if (sel_ready) begin
          memory_ready = 1'b1;
          memory_rdata = sel_rdata;
        end else if (timeout_hit) begin
          memory_ready = 1'b1;
          memory_error = 1'b1;
        end
      end
      ERR: begin
        memory_ready = 1'b1;
        memory_error = 1'b1;
      end
      default: ;
    endcase
  end

  assign slv_instr = instr_q;
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;
  assign slv_wstrb = wstrb_q;

endmodule

// File: tb/tb_bus_router.sv
// Self-checking bench for bus_router: directed vector table, reset-in-flight sequence,
// and random transactions checked against an address-window reference model.
module tb_bus_router;

  localparam int NSLV    = 4;
  localparam int TIMEOUT = 8;

  logic                clock = 1'b0;
  logic                reset;
  logic                memory_valid;
  logic                memory_instr;
  logic [31:0]         memory_addr;
  logic [31:0]         memory_wdata;
  logic [3:0]          memory_wstrb;
  logic [31:0]         memory_rdata;
  logic                memory_ready;
  logic                memory_error;
  logic [NSLV-1:0]     slv_valid;
  logic                slv_instr;
  logic [31:0]         slv_addr;
  logic [31:0]         slv_wdata;
  logic [3:0]          slv_wstrb;
  logic [NSLV*32-1:0]  slv_rdata;
  logic [NSLV-1:0]     slv_ready;

  int errors = 0;
  int checks = 0;

  bus_router #(.NSLV(NSLV), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
    .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
    .memory_ready(memory_ready), .memory_error(memory_error),
    .slv_valid(slv_valid), .slv_instr(slv_instr), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb), .slv_rdata(slv_rdata), .slv_ready(slv_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        instr;
    int          ready_at;
    logic [31:0] rdata;
    logic [3:0]  exp_valid;
    logic [31:0] exp_saddr;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  // Memory map of the default configuration, slave index order.
  logic [31:0] ref_base [4] = '{32'h0000_0000, 32'h0200_0000, 32'h1000_0000, 32'h8000_0000};
  logic [31:0] ref_top  [4] = '{32'h0010_0000, 32'h0200_C000, 32'h1000_1000, 32'h8010_0000};

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a >= ref_base[i] && a < ref_top[i]) return i;
    return -1;
  endfunction

  function automatic vec_t ref_model(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                                     input logic ins, input int rdy, input logic [31:0] rd);
    vec_t v;
    int   idx;
    idx = ref_decode(a);
    v.addr = a; v.wstrb = ws; v.wdata = wd; v.instr = ins; v.ready_at = rdy; v.rdata = rd;
    if (idx < 0) begin
      v.exp_valid = 4'b0000; v.exp_saddr = 32'h0; v.exp_done = 1; v.exp_err = 1'b1;
    end else begin
      v.exp_valid = 4'b0001 << idx;
      v.exp_saddr = a - ref_base[idx];
      if (rdy >= 1 && rdy <= TIMEOUT) begin
        v.exp_done = rdy; v.exp_err = 1'b0;
      end else begin
        v.exp_done = TIMEOUT; v.exp_err = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one transaction starting just after a rising edge in an IDLE cycle.
  task automatic applyStimulus(input vec_t v);
    int          idx;
    logic        exp_ready;
    logic [31:0] exp_rd;
    idx = -1;
    for (int i = 0; i < NSLV; i++) if (v.exp_valid[i]) idx = i;
    memory_valid = 1'b1;
    memory_addr  = v.addr;
    memory_wdata = v.wdata;
    memory_wstrb = v.wstrb;
    memory_instr = v.instr;
    slv_ready    = '0;
    @(posedge clock); #1;
    for (int k = 1; k <= v.exp_done; k++) begin
      for (int i = 0; i < NSLV; i++) begin
        slv_rdata[i*32 +: 32] = $urandom;
        slv_ready[i]          = 1'($urandom_range(0, 1));
      end
      if (idx >= 0) begin
        slv_ready[idx]          = (k == v.ready_at);
        slv_rdata[idx*32 +: 32] = v.rdata;
      end
      @(negedge clock);
      checkOutput($sformatf("slv_valid@%0d addr=%h", k, v.addr), 64'(slv_valid), 64'(v.exp_valid));
      if (k == 1 && idx >= 0)
        checkOutput($sformatf("payload addr=%h", v.addr),
                    {slv_addr, slv_wdata[26:0], slv_wstrb, slv_instr},
                    {v.exp_saddr, v.wdata[26:0], v.wstrb, v.instr});
      exp_ready = (k == v.exp_done);
      exp_rd    = (exp_ready && !v.exp_err) ? v.rdata : 32'h0;
      checkOutput($sformatf("response@%0d addr=%h", k, v.addr),
                  64'({memory_ready, memory_error, memory_rdata}),
                  64'({exp_ready, exp_ready & v.exp_err, exp_rd}));
      @(posedge clock); #1;
    end
    memory_valid = 1'b0;
    slv_ready    = '1;
    @(negedge clock);
    checkOutput($sformatf("idle after addr=%h", v.addr),
                64'({slv_valid, memory_ready, memory_error, memory_rdata}), 64'h0);
    slv_ready = '0;
    @(posedge clock); #1;
  endtask

  vec_t vecs [12];

  initial begin
    vec_t rv;
    logic [31:0] a;
    int          r;

    vecs[0]  = '{32'h0000_0010, 4'h0, 32'h0,    1'b0, 2, 32'hDEAD_BEEF, 4'b0001, 32'h10,      2, 1'b0};
    vecs[1]  = '{32'h0200_4000, 4'hF, 32'h55,   1'b0, 1, 32'h0,         4'b0010, 32'h4000,    1, 1'b0};
    vecs[2]  = '{32'h3000_0000, 4'h0, 32'h0,    1'b0, 1, 32'h1111,      4'b0000, 32'h0,       1, 1'b1};
    vecs[3]  = '{32'h8000_0000, 4'h0, 32'h0,    1'b0, 0, 32'h0,         4'b1000, 32'h0,       8, 1'b1};
    vecs[4]  = '{32'h0000_0020, 4'h0, 32'h0,    1'b1, 4, 32'hCAFE_F00D, 4'b0001, 32'h20,      4, 1'b0};
    vecs[5]  = '{32'h1000_0ABC, 4'h3, 32'hA5A5, 1'b0, 8, 32'h0BAD_F00D, 4'b0100, 32'hABC,     8, 1'b0};
    vecs[6]  = '{32'h000F_FFFC, 4'h0, 32'h0,    1'b0, 3, 32'h1,         4'b0001, 32'hF_FFFC,  3, 1'b0};
    vecs[7]  = '{32'h0010_0000, 4'h0, 32'h0,    1'b0, 1, 32'h7,         4'b0000, 32'h0,       1, 1'b1};
    vecs[8]  = '{32'h0200_BFFC, 4'h0, 32'h0,    1'b0, 1, 32'h2,         4'b0010, 32'hBFFC,    1, 1'b0};
    vecs[9]  = '{32'h0200_C000, 4'h0, 32'h0,    1'b0, 1, 32'h8,         4'b0000, 32'h0,       1, 1'b1};
    vecs[10] = '{32'h800F_FFFC, 4'h1, 32'h99,   1'b0, 1, 32'h3,         4'b1000, 32'hF_FFFC,  1, 1'b0};
    vecs[11] = '{32'h8010_0000, 4'h0, 32'h0,    1'b0, 1, 32'h9,         4'b0000, 32'h0,       1, 1'b1};

    reset = 1'b1;
    memory_valid = 1'b0; memory_instr = 1'b0; memory_addr = '0; memory_wdata = '0; memory_wstrb = '0;
    slv_rdata = '0; slv_ready = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset outputs",
                64'({slv_valid, memory_ready, memory_error, memory_rdata}), 64'h0);
    checkOutput("reset payload", {slv_addr, slv_wdata}, 64'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Reset asserted in BUSY must clear outputs without a clock edge.
    memory_valid = 1'b1; memory_addr = 32'h40; memory_wstrb = 4'h0; memory_instr = 1'b0;
    @(posedge clock); #1;
    slv_ready = 4'b0001;
    slv_rdata[31:0] = 32'h1234_5678;
    #1;
    checkOutput("busy before reset", 64'({slv_valid, memory_ready, memory_rdata}),
                64'({4'b0001, 1'b1, 32'h1234_5678}));
    reset = 1'b1;
    #1;
    checkOutput("async reset", 64'({slv_valid, memory_ready, memory_error, memory_rdata}), 64'h0);
    memory_valid = 1'b0; slv_ready = '0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    applyStimulus(ref_model(32'h0, 4'h0, 32'h0, 1'b0, 2, 32'h0F0F_0F0F));

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 4);
      if (r < 4) a = ref_base[r] + (($urandom % (ref_top[r] - ref_base[r])) & 32'hFFFF_FFFC);
      else       a = $urandom;
      rv = ref_model(a, 4'($urandom), $urandom, 1'($urandom), $urandom_range(1, 10), $urandom);
      applyStimulus(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
